// File: rtl/text_buffer_writer_if.sv
// Upstream character handshake plus character-RAM write port of the text buffer writer.
interface text_buffer_writer_if;
  logic       in_valid;
  logic [6:0] in_ascii;
  logic       in_ready;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [6:0] wr_data;

  modport master (
    output in_valid, in_ascii,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_ascii,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_buffer_writer.sv
// Turns a stream of ASCII codes into writes to a 32x4 character RAM, with cursor
// control codes (CR, LF, BS) and a full-screen clear sweep on form feed.
module text_buffer_writer #(
  parameter logic [6:0] BLANK_CHAR = 7'h20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  text_buffer_writer_if.slave  bus,
  output logic [4:0]           cursor_col,
  output logic [1:0]           cursor_row,
  output logic                 busy
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state_q, state_d;
  logic [4:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [6:0] sweep_q, sweep_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [6:0] wr_data_q, wr_data_d;
  logic       printable;

  // Gated by reset_n so the upstream sees not-ready while reset is held.
  assign bus.in_ready = reset_n & (state_q == IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;
  assign busy         = (state_q == CLEAR);
  assign printable    = (bus.in_ascii >= 7'h20) && (bus.in_ascii != 7'h7F);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    sweep_d   = sweep_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {row_q, col_q};
            wr_data_d = bus.in_ascii;
            col_d     = col_q + 5'd1;
            if (col_q == 5'd31) begin
              row_d = row_q + 2'd1;
            end
          end else begin
            case (bus.in_ascii)
              7'h0D: col_d = 5'd0;
              7'h0A: row_d = row_q + 2'd1;
              7'h08: begin
                if (col_q != 5'd0) begin
                  col_d     = col_q - 5'd1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {row_q, col_q - 5'd1};
                  wr_data_d = BLANK_CHAR;
                end else if (row_q != 2'd0) begin
                  row_d     = row_q - 2'd1;
                  col_d     = 5'd31;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {row_q - 2'd1, 5'd31};
                  wr_data_d = BLANK_CHAR;
                end
              end
              // The sweep's first write (address 0) issues on the FF accept edge.
              7'h0C: begin
                state_d   = CLEAR;
                sweep_d   = 7'd0;
                wr_en_d   = 1'b1;
                wr_addr_d = 7'd0;
                wr_data_d = BLANK_CHAR;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        // sweep_q holds the address currently on the bus; issue the next one.
        sweep_d   = sweep_q + 7'd1;
        wr_en_d   = 1'b1;
        wr_addr_d = sweep_q + 7'd1;
        wr_data_d = BLANK_CHAR;
        if (sweep_q == 7'd126) begin
          state_d = IDLE;
          col_d   = 5'd0;
          row_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= 5'd0;
      row_q     <= 2'd0;
      sweep_q   <= 7'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 7'd0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sweep_q   <= sweep_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: reference model feeding a write scoreboard, plus a
// vector table and hand-written sequences for wrap, clear sweep and mid-sweep reset.
module tb_text_buffer_writer;
  localparam logic [6:0] BLANK = 7'h20;

  logic       clk;
  logic       reset_n;
  logic [4:0] cursor_col;
  logic [1:0] cursor_row;
  logic       busy;

  text_buffer_writer_if bus ();

  text_buffer_writer #(.BLANK_CHAR(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cursor kept as one 7-bit screen position {row,col}.
  logic [13:0] exp_q[$];
  logic [6:0]  m_pos   = 7'd0;
  logic        m_clear = 1'b0;
  logic [6:0]  m_sweep = 7'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos   <= 7'd0;
      m_clear <= 1'b0;
      m_sweep <= 7'd0;
      exp_q.delete();
    end else if (m_clear) begin
      exp_q.push_back({m_sweep, BLANK});
      m_sweep <= m_sweep + 7'd1;
      if (m_sweep == 7'd127) begin
        m_clear <= 1'b0;
        m_pos   <= 7'd0;
      end
    end else if (bus.in_valid) begin
      if (bus.in_ascii >= 7'h20 && bus.in_ascii <= 7'h7E) begin
        exp_q.push_back({m_pos, bus.in_ascii});
        m_pos <= m_pos + 7'd1;
      end else if (bus.in_ascii == 7'h0D) begin
        m_pos[4:0] <= 5'd0;
      end else if (bus.in_ascii == 7'h0A) begin
        m_pos[6:5] <= m_pos[6:5] + 2'd1;
      end else if (bus.in_ascii == 7'h08) begin
        if (m_pos != 7'd0) begin
          exp_q.push_back({m_pos - 7'd1, BLANK});
          m_pos <= m_pos - 7'd1;
        end
      end else if (bus.in_ascii == 7'h0C) begin
        exp_q.push_back({7'd0, BLANK});
        m_clear <= 1'b1;
        m_sweep <= 7'd1;
      end
    end
  end

  // Scoreboard and status monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", {18'd0, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          chk("sb_write", {18'd0, bus.wr_addr, bus.wr_data}, {18'd0, e});
        end
      end else begin
        chk("sb_missing_write", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      chk("sb_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, m_pos});
      chk("sb_ready", 32'(bus.in_ready), 32'(reset_n && !m_clear));
      chk("sb_busy", 32'(busy), 32'(m_clear));
    end
  end

  task automatic send(input logic [6:0] c);
    int w;
    w = 0;
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1 t=%0t", $time);
    end
    bus.in_valid = 1'b1;
    bus.in_ascii = c;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("TX ascii=%02h wr_en=%0b addr=%0d data=%02h row=%0d col=%0d",
             c, bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col);
  endtask

  typedef struct packed {
    logic [6:0] ascii;
    logic       exp_wr;
    logic [6:0] exp_addr;
    logic [6:0] exp_data;
    logic [1:0] exp_row;
    logic [4:0] exp_col;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int n_wr;
    int w;
    tbl[0]  = '{7'h48, 1'b1, 7'd0,  7'h48, 2'd0, 5'd1};
    tbl[1]  = '{7'h49, 1'b1, 7'd1,  7'h49, 2'd0, 5'd2};
    tbl[2]  = '{7'h0D, 1'b0, 7'd0,  7'h00, 2'd0, 5'd0};
    tbl[3]  = '{7'h0A, 1'b0, 7'd0,  7'h00, 2'd1, 5'd0};
    tbl[4]  = '{7'h08, 1'b1, 7'd31, 7'h20, 2'd0, 5'd31};
    tbl[5]  = '{7'h0D, 1'b0, 7'd0,  7'h00, 2'd0, 5'd0};
    tbl[6]  = '{7'h08, 1'b0, 7'd0,  7'h00, 2'd0, 5'd0};
    tbl[7]  = '{7'h7F, 1'b0, 7'd0,  7'h00, 2'd0, 5'd0};
    tbl[8]  = '{7'h01, 1'b0, 7'd0,  7'h00, 2'd0, 5'd0};
    tbl[9]  = '{7'h0A, 1'b0, 7'd0,  7'h00, 2'd1, 5'd0};
    tbl[10] = '{7'h0A, 1'b0, 7'd0,  7'h00, 2'd2, 5'd0};
    tbl[11] = '{7'h61, 1'b1, 7'd64, 7'h61, 2'd2, 5'd1};
    tbl[12] = '{7'h62, 1'b1, 7'd65, 7'h62, 2'd2, 5'd2};
    tbl[13] = '{7'h63, 1'b1, 7'd66, 7'h63, 2'd2, 5'd3};
    tbl[14] = '{7'h64, 1'b1, 7'd67, 7'h64, 2'd2, 5'd4};
    tbl[15] = '{7'h65, 1'b1, 7'd68, 7'h65, 2'd2, 5'd5};
    tbl[16] = '{7'h0D, 1'b0, 7'd0,  7'h00, 2'd2, 5'd0};
    tbl[17] = '{7'h0A, 1'b0, 7'd0,  7'h00, 2'd3, 5'd0};
    tbl[18] = '{7'h0A, 1'b0, 7'd0,  7'h00, 2'd0, 5'd0};

    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ascii = 7'd0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(bus.in_ready), 32'd0);
    chk("rst_wr_en",   32'(bus.wr_en),    32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr),  32'd0);
    chk("rst_wr_data", 32'(bus.wr_data),  32'd0);
    chk("rst_busy",    32'(busy),         32'd0);
    chk("rst_cursor",  {25'd0, cursor_row, cursor_col}, 32'd0);
    #2 reset_n = 1'b1;
    #1 chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    mon_en = 1'b1;
    @(negedge clk);

    // Back-to-back vectors: HI, BS across row, BS at origin, ignored codes, CR/LF.
    for (int i = 0; i < 19; i++) begin
      send(tbl[i].ascii);
      chk("vec_wr_en", 32'(bus.wr_en), 32'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) begin
        chk("vec_wr_addr", 32'(bus.wr_addr), 32'(tbl[i].exp_addr));
        chk("vec_wr_data", 32'(bus.wr_data), 32'(tbl[i].exp_data));
      end
      chk("vec_cursor", {25'd0, cursor_row, cursor_col},
          {25'd0, tbl[i].exp_row, tbl[i].exp_col});
    end

    // Fill row 3 and wrap past the last cell back to the origin.
    repeat (3) send(7'h0A);
    chk("row3_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 2'd3, 5'd0});
    for (int i = 0; i < 32; i++) send(7'h41 + 7'(i));
    chk("wrap_wr_addr", 32'(bus.wr_addr), 32'd127);
    chk("wrap_wr_data", 32'(bus.wr_data), 32'h60);
    chk("wrap_cursor",  {25'd0, cursor_row, cursor_col}, 32'd0);

    // Form feed with in_valid held high carrying 'A' throughout the sweep.
    bus.in_valid = 1'b1;
    bus.in_ascii = 7'h0C;
    @(posedge clk);
    @(negedge clk);
    bus.in_ascii = 7'h41;
    $display("TX ascii=0c clear sweep start");
    for (int c = 0; c < 128; c++) begin
      if (c > 0) @(negedge clk);
      chk("clr_wr_en",   32'(bus.wr_en),   32'd1);
      chk("clr_wr_addr", 32'(bus.wr_addr), 32'(c));
      chk("clr_wr_data", 32'(bus.wr_data), 32'(BLANK));
      if (c < 127) begin
        chk("clr_ready", 32'(bus.in_ready), 32'd0);
        chk("clr_busy",  32'(busy),         32'd1);
      end else begin
        chk("clr_end_ready", 32'(bus.in_ready), 32'd1);
        chk("clr_end_busy",  32'(busy),         32'd0);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("TX ascii=41 after sweep addr=%0d data=%02h", bus.wr_addr, bus.wr_data);
    chk("held_wr_en",   32'(bus.wr_en),   32'd1);
    chk("held_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("held_wr_data", 32'(bus.wr_data), 32'h41);
    chk("held_cursor",  {25'd0, cursor_row, cursor_col}, 32'd1);

    // Reset in the middle of a sweep.
    send(7'h0C);
    w = 0;
    while (!(bus.wr_en && bus.wr_addr == 7'd60) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("sweep_reaches_60", 32'(bus.wr_addr), 32'd60);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(bus.wr_en),    32'd0);
    chk("async_rst_busy",  32'(busy),         32'd0);
    chk("async_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("rel_ready",  32'(bus.in_ready), 32'd1);
    chk("rel_cursor", {25'd0, cursor_row, cursor_col}, 32'd0);
    n_wr = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.wr_en) n_wr++;
    end
    chk("no_sweep_resume", 32'(n_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
